cg_vector_address_sequencer: RTL and testbench

- Parametrised successor to the CG solver's address control: one controller drives read/write address counters for NUM_CH vector memories (X, R, P, P_v2, ...), plus the A-matrix read address.
- Adds a clean wrap at vector length, per-channel wrap pulses, an explicit phase FSM, and an iteration cap.
- Sits between the ALU/vector-unit strobes and the vector/matrix memories.

---
 rtl/cg_vector_address_sequencer.sv | 219 +++++++++++++++++++++
 tb/tb_cg_vector_address_sequencer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cg_vector_address_sequencer.sv
// cg_vector_address_sequencer: address control for the CG solver.
// Drives per-channel read/write pointers for NUM_CH vector memories
// plus the A-matrix read address, sequenced by an IDLE/PRE/RUN/
// ITER_END/HALT phase FSM with an iteration cap.
// Ports: clk, reset (async, active low); total, start,
// memories_pre_preprocess, rd_inc/wr_inc, finish_alu, finish_all in;
// rd_addr/wr_addr (channel i at [i*ADDR_WIDTH +: ADDR_WIDTH]),
// rd_wrap/wr_wrap, memoryA_read_address, iteration_counter, halt,
// busy, state out.
// Optional macro CG_CYCLE_COUNTER_EN adds cycle_count and
// last_iter_cycles outputs.
module cg_vector_address_sequencer #(
   parameter int NUM_CH       = 4,
   parameter int ADDR_WIDTH   = 32,
   parameter int A_ADDR_WIDTH = 32,
   parameter int NO_OF_UNITS  = 8,
   parameter int ITER_WIDTH   = 11,
   parameter int MAX_ITER     = 1024
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [31:0]                  total,
   input  logic                         start,
   input  logic                         memories_pre_preprocess,
   input  logic [NUM_CH-1:0]            rd_inc,
   input  logic [NUM_CH-1:0]            wr_inc,
   input  logic                         finish_alu,
   input  logic                         finish_all,
   output logic [NUM_CH*ADDR_WIDTH-1:0] rd_addr,
   output logic [NUM_CH*ADDR_WIDTH-1:0] wr_addr,
   output logic [NUM_CH-1:0]            rd_wrap,
   output logic [NUM_CH-1:0]            wr_wrap,
   output logic [A_ADDR_WIDTH-1:0]      memoryA_read_address,
   output logic [ITER_WIDTH-1:0]        iteration_counter,
   output logic                         halt,
   output logic                         busy,
`ifdef CG_CYCLE_COUNTER_EN
   output logic [31:0]                  cycle_count,
   output logic [31:0]                  last_iter_cycles,
`endif
   output logic [2:0]                   state
);

   localparam int SHIFT = $clog2(NO_OF_UNITS);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_PRE      = 3'd1,
      S_RUN      = 3'd2,
      S_ITER_END = 3'd3,
      S_HALT     = 3'd4
   } state_e;

   localparam logic [ADDR_WIDTH-1:0]   A_ONE  = ADDR_WIDTH'(1);
   localparam logic [A_ADDR_WIDTH-1:0] AM_ONE = A_ADDR_WIDTH'(1);
   localparam logic [ITER_WIDTH-1:0]   IT_ONE = ITER_WIDTH'(1);
   localparam logic [ITER_WIDTH-1:0]   IT_CAP = ITER_WIDTH'(MAX_ITER);

   state_e                              state_q, state_d;
   logic [ADDR_WIDTH-1:0]               limit_q, limit_d;
   logic [NUM_CH-1:0][ADDR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
   logic [NUM_CH-1:0][ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
   logic [NUM_CH-1:0]                   rd_wrap_q, rd_wrap_d;
   logic [NUM_CH-1:0]                   wr_wrap_q, wr_wrap_d;
   logic [A_ADDR_WIDTH-1:0]             amem_q, amem_d;
   logic [ITER_WIDTH-1:0]               iter_q, iter_d;

   logic [31:0]           total_sh;
   logic [ADDR_WIDTH-1:0] new_limit;
   logic [ADDR_WIDTH-1:0] limit_m1;
   logic [ITER_WIDTH-1:0] iter_inc;

   assign total_sh  = total >> SHIFT;
   assign new_limit = ADDR_WIDTH'(total_sh);
   assign limit_m1  = limit_q - A_ONE;
   // Saturating increment: the counter sticks at all ones.
   assign iter_inc  = (iter_q == '1) ? iter_q : iter_q + IT_ONE;

   always_comb begin
      state_d   = state_q;
      limit_d   = limit_q;
      rd_ptr_d  = rd_ptr_q;
      wr_ptr_d  = wr_ptr_q;
      rd_wrap_d = '0;
      wr_wrap_d = '0;
      amem_d    = amem_q;
      iter_d    = iter_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               limit_d = new_limit;
               // A zero-length vector has nothing to sequence.
               if (new_limit != '0)
                  state_d = memories_pre_preprocess ? S_PRE : S_RUN;
            end
         end
         S_PRE: begin
            if (finish_all) begin
               state_d = S_HALT;
               iter_d  = iter_inc;
            end else if (memories_pre_preprocess) begin
               amem_d = amem_q + AM_ONE;
            end else begin
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (finish_all) begin
               state_d = S_HALT;
               iter_d  = iter_inc;
            end else if (finish_alu) begin
               rd_ptr_d = '0;
               wr_ptr_d = '0;
               amem_d   = '1;
               iter_d   = iter_inc;
               state_d  = S_ITER_END;
            end else begin
               // Wrap on limit-1 so a pointer never shows limit.
               for (int i = 0; i < NUM_CH; i++) begin
                  if (rd_inc[i]) begin
                     if (rd_ptr_q[i] == limit_m1) begin
                        rd_ptr_d[i]  = '0;
                        rd_wrap_d[i] = 1'b1;
                     end else begin
                        rd_ptr_d[i] = rd_ptr_q[i] + A_ONE;
                     end
                  end
                  if (wr_inc[i]) begin
                     if (wr_ptr_q[i] == limit_m1) begin
                        wr_ptr_d[i]  = '0;
                        wr_wrap_d[i] = 1'b1;
                     end else begin
                        wr_ptr_d[i] = wr_ptr_q[i] + A_ONE;
                     end
                  end
               end
            end
         end
         S_ITER_END: begin
            if (finish_all) begin
               state_d = S_HALT;
               iter_d  = iter_inc;
            end else if (iter_q == IT_CAP) begin
               state_d = S_HALT;
            end else begin
               state_d = memories_pre_preprocess ? S_PRE : S_RUN;
            end
         end
         S_HALT: begin
            state_d = S_HALT;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         limit_q   <= '0;
         rd_ptr_q  <= '0;
         wr_ptr_q  <= '0;
         rd_wrap_q <= '0;
         wr_wrap_q <= '0;
         amem_q    <= '1;
         iter_q    <= '0;
      end else begin
         state_q   <= state_d;
         limit_q   <= limit_d;
         rd_ptr_q  <= rd_ptr_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_wrap_q <= rd_wrap_d;
         wr_wrap_q <= wr_wrap_d;
         amem_q    <= amem_d;
         iter_q    <= iter_d;
      end
   end

   assign rd_addr              = rd_ptr_q;
   assign wr_addr              = wr_ptr_q;
   assign rd_wrap              = rd_wrap_q;
   assign wr_wrap              = wr_wrap_q;
   assign memoryA_read_address = amem_q;
   assign iteration_counter    = iter_q;
   assign state                = state_q;
   assign halt                 = (state_q == S_HALT);
   assign busy                 = (state_q == S_PRE) ||
                                 (state_q == S_RUN) ||
                                 (state_q == S_ITER_END);

`ifdef CG_CYCLE_COUNTER_EN
   logic [31:0] cyc_q, cyc_d;
   logic [31:0] last_q, last_d;

   always_comb begin
      cyc_d  = cyc_q;
      last_d = last_q;
      if (busy && (cyc_q != '1))
         cyc_d = cyc_q + 32'd1;
      if (state_q == S_ITER_END)
         last_d = cyc_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cyc_q  <= '0;
         last_q <= '0;
      end else begin
         cyc_q  <= cyc_d;
         last_q <= last_d;
      end
   end

   assign cycle_count      = cyc_q;
   assign last_iter_cycles = last_q;
`endif

endmodule

// File: tb/tb_cg_vector_address_sequencer.sv
// Testbench for cg_vector_address_sequencer.
// Table-driven RUN/ITER_END/HALT vectors plus directed sequences.
module tb_cg_vector_address_sequencer;

   logic        clk;
   logic        reset;
   logic [31:0] total;
   logic        start;
   logic        mpp;
   logic [3:0]  rd_inc;
   logic [3:0]  wr_inc;
   logic        finish_alu;
   logic        finish_all;
   logic [31:0] rd_addr;
   logic [31:0] wr_addr;
   logic [3:0]  rd_wrap;
   logic [3:0]  wr_wrap;
   logic [7:0]  amem;
   logic [10:0] iter;
   logic        halt;
   logic        busy;
   logic [2:0]  state;
`ifdef CG_CYCLE_COUNTER_EN
   logic [31:0] cycle_count;
   logic [31:0] last_iter_cycles;
`endif

   int checks   = 0;
   int failures = 0;

   cg_vector_address_sequencer #(
      .NUM_CH(4), .ADDR_WIDTH(8), .A_ADDR_WIDTH(8),
      .NO_OF_UNITS(8), .ITER_WIDTH(11), .MAX_ITER(3)
   ) dut (
      .clk(clk), .reset(reset), .total(total), .start(start),
      .memories_pre_preprocess(mpp),
      .rd_inc(rd_inc), .wr_inc(wr_inc),
      .finish_alu(finish_alu), .finish_all(finish_all),
      .rd_addr(rd_addr), .wr_addr(wr_addr),
      .rd_wrap(rd_wrap), .wr_wrap(wr_wrap),
      .memoryA_read_address(amem),
      .iteration_counter(iter),
      .halt(halt), .busy(busy),
`ifdef CG_CYCLE_COUNTER_EN
      .cycle_count(cycle_count),
      .last_iter_cycles(last_iter_cycles),
`endif
      .state(state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       start;
      logic [3:0] rd_inc;
      logic [3:0] wr_inc;
      logic       fa;
      logic       fall;
      logic [2:0] st;
      logic [31:0] rd;
      logic [31:0] wr;
      logic [3:0] rw;
      logic [3:0] ww;
      logic [10:0] it;
      logic       hl;
   } vec_t;

   vec_t vt [15];

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      start      = 1'b0;
      mpp        = 1'b0;
      rd_inc     = '0;
      wr_inc     = '0;
      finish_alu = 1'b0;
      finish_all = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b0;
      cyc();
      cyc();
      reset = 1'b1;
      cyc();
   endtask

   initial begin
      total = 32'd0;
      idle_inputs();
      reset = 1'b1;
      #2;
      do_reset();

      chk("reset state", 64'(state), 64'd0);
      chk("reset rd_addr", 64'(rd_addr), 64'd0);
      chk("reset wr_addr", 64'(wr_addr), 64'd0);
      chk("reset wraps", 64'({rd_wrap, wr_wrap}), 64'd0);
      chk("reset amem", 64'(amem), 64'hFF);
      chk("reset iter", 64'(iter), 64'd0);
      chk("reset halt/busy", 64'({halt, busy}), 64'd0);
`ifdef CG_CYCLE_COUNTER_EN
      chk("reset cycle_count", 64'(cycle_count), 64'd0);
`endif

      // start, rd_inc, wr_inc, fa, fall, st, rd, wr, rw, ww, it, hl
      vt[0]  = '{0, 4'h2, 4'h1, 0, 0, 3'd2, 32'h00000100, 32'h00000001, 4'h0, 4'h0, 11'd0, 0};
      vt[1]  = '{0, 4'h2, 4'h1, 0, 0, 3'd2, 32'h00000200, 32'h00000002, 4'h0, 4'h0, 11'd0, 0};
      vt[2]  = '{0, 4'h2, 4'h1, 0, 0, 3'd2, 32'h00000300, 32'h00000003, 4'h0, 4'h0, 11'd0, 0};
      vt[3]  = '{0, 4'h2, 4'h0, 0, 0, 3'd2, 32'h00000400, 32'h00000003, 4'h0, 4'h0, 11'd0, 0};
      vt[4]  = '{0, 4'h2, 4'h0, 0, 0, 3'd2, 32'h00000500, 32'h00000003, 4'h0, 4'h0, 11'd0, 0};
      vt[5]  = '{0, 4'h2, 4'h0, 0, 0, 3'd2, 32'h00000600, 32'h00000003, 4'h0, 4'h0, 11'd0, 0};
      vt[6]  = '{0, 4'h2, 4'h0, 0, 0, 3'd2, 32'h00000700, 32'h00000003, 4'h0, 4'h0, 11'd0, 0};
      vt[7]  = '{0, 4'h2, 4'h0, 0, 0, 3'd2, 32'h00000000, 32'h00000003, 4'h2, 4'h0, 11'd0, 0};
      vt[8]  = '{0, 4'h2, 4'h0, 0, 0, 3'd2, 32'h00000100, 32'h00000003, 4'h0, 4'h0, 11'd0, 0};
      vt[9]  = '{0, 4'h2, 4'h0, 0, 0, 3'd2, 32'h00000200, 32'h00000003, 4'h0, 4'h0, 11'd0, 0};
      vt[10] = '{0, 4'h2, 4'h1, 1, 0, 3'd3, 32'h00000000, 32'h00000000, 4'h0, 4'h0, 11'd1, 0};
      vt[11] = '{0, 4'h0, 4'h0, 0, 0, 3'd2, 32'h00000000, 32'h00000000, 4'h0, 4'h0, 11'd1, 0};
      vt[12] = '{0, 4'hF, 4'h8, 0, 0, 3'd2, 32'h01010101, 32'h01000000, 4'h0, 4'h0, 11'd1, 0};
      vt[13] = '{0, 4'h0, 4'h0, 1, 1, 3'd4, 32'h01010101, 32'h01000000, 4'h0, 4'h0, 11'd2, 1};
      vt[14] = '{1, 4'hF, 4'hF, 1, 0, 3'd4, 32'h01010101, 32'h01000000, 4'h0, 4'h0, 11'd2, 1};

      total = 32'd64;
      start = 1'b1;
      cyc();
      start = 1'b0;
      chk("start to RUN", 64'(state), 64'd2);
      for (int i = 0; i < 15; i++) begin
         start      = vt[i].start;
         rd_inc     = vt[i].rd_inc;
         wr_inc     = vt[i].wr_inc;
         finish_alu = vt[i].fa;
         finish_all = vt[i].fall;
         cyc();
         chk($sformatf("row%0d state", i), 64'(state), 64'(vt[i].st));
         chk($sformatf("row%0d rd_addr", i), 64'(rd_addr), 64'(vt[i].rd));
         chk($sformatf("row%0d wr_addr", i), 64'(wr_addr), 64'(vt[i].wr));
         chk($sformatf("row%0d rd_wrap", i), 64'(rd_wrap), 64'(vt[i].rw));
         chk($sformatf("row%0d wr_wrap", i), 64'(wr_wrap), 64'(vt[i].ww));
         chk($sformatf("row%0d iter", i), 64'(iter), 64'(vt[i].it));
         chk($sformatf("row%0d halt", i), 64'(halt), 64'(vt[i].hl));
         chk($sformatf("row%0d amem", i), 64'(amem), 64'hFF);
      end
      idle_inputs();

      // Preload: A address counts from all ones, strobes ignored.
      do_reset();
      total = 32'd64;
      start = 1'b1;
      mpp   = 1'b1;
      cyc();
      start  = 1'b0;
      rd_inc = 4'hF;
      wr_inc = 4'hF;
      chk("pre state", 64'(state), 64'd1);
      chk("pre amem start", 64'(amem), 64'hFF);
      for (int k = 0; k < 5; k++) begin
         cyc();
         chk($sformatf("pre amem%0d", k), 64'(amem), 64'(k));
         chk($sformatf("pre state%0d", k), 64'(state), 64'd1);
      end
      chk("pre rd ignored", 64'({rd_addr, wr_addr}), 64'd0);
      mpp    = 1'b0;
      rd_inc = '0;
      wr_inc = '0;
      cyc();
      chk("pre to RUN", 64'(state), 64'd2);
      chk("pre amem hold", 64'(amem), 64'd4);
      chk("busy in RUN", 64'(busy), 64'd1);

      // finish_all straight out of PRE.
      do_reset();
      total = 32'd64;
      start = 1'b1;
      mpp   = 1'b1;
      cyc();
      idle_inputs();
      mpp        = 1'b1;
      finish_all = 1'b1;
      cyc();
      idle_inputs();
      chk("pre finish_all state", 64'(state), 64'd4);
      chk("pre finish_all iter", 64'(iter), 64'd1);
      chk("pre finish_all halt", 64'(halt), 64'd1);

      // Iteration cap: third ITER_END forces HALT.
      do_reset();
      total = 32'd16;
      start = 1'b1;
      cyc();
      start = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         finish_alu = 1'b1;
         cyc();
         finish_alu = 1'b0;
         chk($sformatf("cap iter_end%0d", k), 64'(state), 64'd3);
         chk($sformatf("cap iter%0d", k), 64'(iter), 64'(k));
         cyc();
         if (k < 3)
            chk($sformatf("cap run%0d", k), 64'(state), 64'd2);
      end
      chk("cap halt state", 64'(state), 64'd4);
      chk("cap halt flag", 64'(halt), 64'd1);

      // Limit zero: start ignored.
      do_reset();
      total = 32'd4;
      start = 1'b1;
      cyc();
      chk("limit0 idle", 64'(state), 64'd0);
      total = 32'd7;
      cyc();
      start = 1'b0;
      chk("limit0 idle b", 64'(state), 64'd0);
      chk("limit0 busy", 64'(busy), 64'd0);

      // Limit 2 wrap on a write pointer.
      total = 32'd16;
      start = 1'b1;
      cyc();
      start  = 1'b0;
      wr_inc = 4'h4;
      cyc();
      chk("lim2 wr1", 64'(wr_addr), 64'h00010000);
      cyc();
      chk("lim2 wr wrap addr", 64'(wr_addr), 64'd0);
      chk("lim2 wr wrap", 64'(wr_wrap), 64'h4);
      wr_inc = '0;
      cyc();
      chk("lim2 wrap clears", 64'(wr_wrap), 64'd0);

      // Asynchronous reset mid-RUN.
      do_reset();
      total = 32'd64;
      start = 1'b1;
      mpp   = 1'b1;
      cyc();
      start = 1'b0;
      cyc();
      cyc();
      mpp = 1'b0;
      cyc();
      rd_inc = 4'h4;
      cyc();
      cyc();
      rd_inc = '0;
      chk("pre-reset rd", 64'(rd_addr), 64'h00020000);
      chk("pre-reset amem", 64'(amem), 64'd1);
      #2;
      reset = 1'b0;
      #1;
      chk("async state", 64'(state), 64'd0);
      chk("async rd", 64'(rd_addr), 64'd0);
      chk("async amem", 64'(amem), 64'hFF);
      chk("async busy", 64'(busy), 64'd0);
`ifdef CG_CYCLE_COUNTER_EN
      chk("async cycle_count", 64'(cycle_count), 64'd0);
`endif
      cyc();
      reset = 1'b1;
      cyc();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
